partial_block_accumulator: RTL and testbench

//  Write-back stage downstream of matrix_multiplier. Takes one 2x2 partial-product block
//  per handshake and adds it into the result matrix in Memory by read-modify-write.

---
 rtl/partial_block_accumulator_if.sv | 50 +++++
 rtl/partial_block_accumulator.sv | 173 +++++++++++++++++
 tb/tb_partial_block_accumulator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/partial_block_accumulator_if.sv
// Handshake and memory-port bundle for partial_block_accumulator.
//   add_*          : upstream partial-block handshake (valid/ack/done, busy)
//   mem_rd_* / mem_wr_* : result-memory read and write ports, one row = {col1, col0}
//   block_count    : completed-block counter
// Modport slave is the accumulator's view; master is the upstream + memory side.
interface partial_block_accumulator_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic                  add_valid;
  logic                  add_overwrite;
  logic                  row_en_1;
  logic                  row_en_2;
  logic [ADDR_W-1:0]     row_1_address;
  logic [ADDR_W-1:0]     row_2_address;
  logic [DATA_W-1:0]     add_data_00;
  logic [DATA_W-1:0]     add_data_01;
  logic [DATA_W-1:0]     add_data_10;
  logic [DATA_W-1:0]     add_data_11;
  logic                  add_ack;
  logic                  add_done;
  logic                  busy;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic [2*DATA_W-1:0]   mem_rd_data;
  logic                  mem_wr_en;
  logic [ADDR_W-1:0]     mem_wr_addr;
  logic [2*DATA_W-1:0]   mem_wr_data;
  logic [15:0]           block_count;

  modport slave (
    input  add_valid, add_overwrite, row_en_1, row_en_2,
    input  row_1_address, row_2_address,
    input  add_data_00, add_data_01, add_data_10, add_data_11,
    input  mem_rd_data,
    output add_ack, add_done, busy,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output block_count
  );

  modport master (
    output add_valid, add_overwrite, row_en_1, row_en_2,
    output row_1_address, row_2_address,
    output add_data_00, add_data_01, add_data_10, add_data_11,
    output mem_rd_data,
    input  add_ack, add_done, busy,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  block_count
  );
endinterface

// File: rtl/partial_block_accumulator.sv
// Accumulates one 2x2 partial-product block per handshake into a result memory
// by read-modify-write (two DATA_W words per row).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : partial_block_accumulator_if.slave (handshake, memory ports, block_count)
// Sequence: IDLE -> RD1 -> WR1 -> RD2 -> WR2 -> DONE -> IDLE; RDx states are
// skipped when overwriting, disabled rows are skipped entirely.
module partial_block_accumulator #(
  parameter int unsigned MEMORY_HEIGHT = 4000,
  parameter int unsigned ADDR_W        = $clog2(MEMORY_HEIGHT),
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SATURATE      = 0
) (
  input logic                    clk,
  input logic                    rst,
  partial_block_accumulator_if.slave bus
);

  localparam int unsigned ROW_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_WR1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_WR2  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Captured copy of the accepted block; upstream may change inputs after ack.
  typedef struct packed {
    logic              overwrite;
    logic              row_en_2;
    logic [ADDR_W-1:0] row_1_address;
    logic [ADDR_W-1:0] row_2_address;
    logic [DATA_W-1:0] d00;
    logic [DATA_W-1:0] d01;
    logic [DATA_W-1:0] d10;
    logic [DATA_W-1:0] d11;
  } block_t;

  state_t      state;
  state_t      state_next;
  block_t      cap;
  block_t      in_blk;
  logic        accept;
  logic        ack_q;
  logic [15:0] count_q;
  logic [DATA_W-1:0] rd_col0;
  logic [DATA_W-1:0] rd_col1;

  // Element add: wrap, or clamp on signed overflow when SATURATE is set.
  function automatic logic [DATA_W-1:0] add_word(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] sum;
    logic              ovf;
    sum = a + b;
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    if ((SATURATE != 0) && ovf) begin
      sum = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return sum;
  endfunction

  assign accept  = (state == ST_IDLE) && bus.add_valid;
  assign rd_col0 = bus.mem_rd_data[DATA_W-1:0];
  assign rd_col1 = bus.mem_rd_data[ROW_W-1:DATA_W];

  assign in_blk.overwrite     = bus.add_overwrite;
  assign in_blk.row_en_2      = bus.row_en_2;
  assign in_blk.row_1_address = bus.row_1_address;
  assign in_blk.row_2_address = bus.row_2_address;
  assign in_blk.d00           = bus.add_data_00;
  assign in_blk.d01           = bus.add_data_01;
  assign in_blk.d10           = bus.add_data_10;
  assign in_blk.d11           = bus.add_data_11;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Block capture, ack pulse and completed-block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap     <= '0;
      ack_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        cap <= in_blk;
      end
      if (state == ST_DONE) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.add_valid) begin
          if (bus.row_en_1) begin
            state_next = bus.add_overwrite ? ST_WR1 : ST_RD1;
          end else if (bus.row_en_2) begin
            state_next = bus.add_overwrite ? ST_WR2 : ST_RD2;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_RD1: state_next = ST_WR1;
      ST_WR1: begin
        if (cap.row_en_2) begin
          state_next = cap.overwrite ? ST_WR2 : ST_RD2;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_RD2:  state_next = ST_WR2;
      ST_WR2:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode; write data uses the read data returned for the preceding RDx.
  always_comb begin
    bus.busy        = 1'b0;
    bus.add_done    = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.busy        = (state != ST_IDLE);
    case (state)
      ST_RD1: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = cap.row_1_address;
      end
      ST_WR1: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = cap.row_1_address;
        bus.mem_wr_data = cap.overwrite ? {cap.d01, cap.d00}
                                        : {add_word(rd_col1, cap.d01), add_word(rd_col0, cap.d00)};
      end
      ST_RD2: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = cap.row_2_address;
      end
      ST_WR2: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = cap.row_2_address;
        bus.mem_wr_data = cap.overwrite ? {cap.d11, cap.d10}
                                        : {add_word(rd_col1, cap.d11), add_word(rd_col0, cap.d10)};
      end
      ST_DONE: bus.add_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.add_ack     = ack_q;
  assign bus.block_count = count_q;

endmodule

// File: tb/tb_partial_block_accumulator.sv
// Directed, table-driven bench for partial_block_accumulator.
// Two instances (wrap and saturating) share the same stimulus, each with its own memory model.
module tb_partial_block_accumulator;
  localparam int unsigned MEMORY_HEIGHT = 4000;
  localparam int unsigned ADDR_W        = $clog2(MEMORY_HEIGHT);
  localparam int unsigned DATA_W        = 32;

  typedef struct {
    logic              ow;
    logic              en1;
    logic              en2;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [31:0]       d00, d01, d10, d11;
    logic [63:0]       pre1, pre2, exp1, exp2;
    int                lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              add_valid, add_overwrite, row_en_1, row_en_2;
  logic [ADDR_W-1:0] row_1_address, row_2_address;
  logic [31:0]       add_data_00, add_data_01, add_data_10, add_data_11;
  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [63:0]       pre_data;

  partial_block_accumulator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  partial_block_accumulator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  partial_block_accumulator #(.MEMORY_HEIGHT(MEMORY_HEIGHT), .ADDR_W(ADDR_W),
                              .DATA_W(DATA_W), .SATURATE(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  partial_block_accumulator #(.MEMORY_HEIGHT(MEMORY_HEIGHT), .ADDR_W(ADDR_W),
                              .DATA_W(DATA_W), .SATURATE(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.add_valid = add_valid;         assign bus1.add_valid = add_valid;
  assign bus0.add_overwrite = add_overwrite; assign bus1.add_overwrite = add_overwrite;
  assign bus0.row_en_1 = row_en_1;           assign bus1.row_en_1 = row_en_1;
  assign bus0.row_en_2 = row_en_2;           assign bus1.row_en_2 = row_en_2;
  assign bus0.row_1_address = row_1_address; assign bus1.row_1_address = row_1_address;
  assign bus0.row_2_address = row_2_address; assign bus1.row_2_address = row_2_address;
  assign bus0.add_data_00 = add_data_00;     assign bus1.add_data_00 = add_data_00;
  assign bus0.add_data_01 = add_data_01;     assign bus1.add_data_01 = add_data_01;
  assign bus0.add_data_10 = add_data_10;     assign bus1.add_data_10 = add_data_10;
  assign bus0.add_data_11 = add_data_11;     assign bus1.add_data_11 = add_data_11;

  // Memory models: one-cycle read latency, write on the strobe edge, bench preload port.
  logic [63:0] mem0 [0:MEMORY_HEIGHT-1];
  logic [63:0] mem1 [0:MEMORY_HEIGHT-1];
  int rd_cnt0 = 0;
  int wr_cnt0 = 0;
  int done_cnt0 = 0;

  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rd_data <= mem0[bus0.mem_rd_addr];
    if (bus0.mem_wr_en) mem0[bus0.mem_wr_addr] <= bus0.mem_wr_data;
    if (pre_en) mem0[pre_addr] <= pre_data;
    if (bus0.mem_rd_en) rd_cnt0 <= rd_cnt0 + 1;
    if (bus0.mem_wr_en) wr_cnt0 <= wr_cnt0 + 1;
    if (bus0.add_done) done_cnt0 <= done_cnt0 + 1;
  end

  always @(posedge clk) begin
    if (bus1.mem_rd_en) bus1.mem_rd_data <= mem1[bus1.mem_rd_addr];
    if (bus1.mem_wr_en) mem1[bus1.mem_wr_addr] <= bus1.mem_wr_data;
    if (pre_en) mem1[pre_addr] <= pre_data;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;
  vec_t        vecs [9];
  vec_t        vpost;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit ow, input bit en1, input bit en2,
                              input int a1, input int a2,
                              input logic [31:0] d00, input logic [31:0] d01,
                              input logic [31:0] d10, input logic [31:0] d11,
                              input logic [63:0] pre1, input logic [63:0] pre2,
                              input logic [63:0] exp1, input logic [63:0] exp2, input int lat);
    vec_t v;
    v.ow = ow; v.en1 = en1; v.en2 = en2;
    v.a1 = ADDR_W'(a1); v.a2 = ADDR_W'(a2);
    v.d00 = d00; v.d01 = d01; v.d10 = d10; v.d11 = d11;
    v.pre1 = pre1; v.pre2 = pre2; v.exp1 = exp1; v.exp2 = exp2; v.lat = lat;
    return v;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    add_overwrite = v.ow; row_en_1 = v.en1; row_en_2 = v.en2;
    row_1_address = v.a1; row_2_address = v.a2;
    add_data_00 = v.d00; add_data_01 = v.d01; add_data_10 = v.d10; add_data_11 = v.d11;
    add_valid = 1'b1;
  endtask

  // Presents a block, drops valid and scrambles inputs at ack, waits (bounded) for done.
  task automatic run_block(input vec_t v, output int ack_at, output int done_at,
                           output logic [63:0] last_rd);
    ack_at = -1; done_at = -1; last_rd = '0;
    @(negedge clk);
    drive(v);
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      @(negedge clk);
      if (bus0.add_ack && ack_at < 0) begin
        ack_at = k;
        add_valid = 1'b0;
        add_overwrite = ~add_overwrite; row_en_1 = ~row_en_1; row_en_2 = ~row_en_2;
        row_1_address = ADDR_W'($urandom_range(MEMORY_HEIGHT - 1));
        row_2_address = ADDR_W'($urandom_range(MEMORY_HEIGHT - 1));
        add_data_00 = $urandom; add_data_01 = $urandom;
        add_data_10 = $urandom; add_data_11 = $urandom;
      end
      if (bus0.mem_wr_en) last_rd = bus0.mem_rd_data;
      if (bus0.add_done) done_at = k;
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag, output logic [63:0] last_rd);
    int ack_at, done_at, rd0, wr0, exp_wr, exp_rd;
    preload(v.a1, v.pre1);
    preload(v.a2, v.pre2);
    rd0 = rd_cnt0; wr0 = wr_cnt0;
    run_block(v, ack_at, done_at, last_rd);
    exp_wr = int'(v.en1) + int'(v.en2);
    exp_rd = v.ow ? 0 : exp_wr;
    exp_count = exp_count + 16'd1;
    check({tag, "_ack_cycle"}, 64'(ack_at), 64'd1);
    check({tag, "_done_cycle"}, 64'(done_at), 64'(v.lat));
    check({tag, "_rd_strobes"}, 64'(rd_cnt0 - rd0), 64'(exp_rd));
    check({tag, "_wr_strobes"}, 64'(wr_cnt0 - wr0), 64'(exp_wr));
    check({tag, "_row1"}, mem0[v.a1], v.exp1);
    check({tag, "_row2"}, mem0[v.a2], v.exp2);
    check({tag, "_count"}, 64'(bus0.block_count), 64'(exp_count));
  endtask

  initial begin
    logic [63:0] last_rd;
    int          ack_a, done_a, ack_b, done_b, wr0, dn0;

    // {col1, col0} rows; -1 = FFFFFFFF, -5 = FFFFFFFB
    vecs[0] = mk(0, 1, 1,  5,  6, 1, 2, 3, 4, {32'd3, 32'd7}, {32'hFFFF_FFFF, 32'd10},
                 {32'd5, 32'd8}, {32'd3, 32'd13}, 5);
    vecs[1] = mk(1, 1, 1,  0,  1, 9, 8, 7, 6, {32'd100, 32'd200}, {32'd300, 32'd400},
                 {32'd8, 32'd9}, {32'd6, 32'd7}, 3);
    vecs[2] = mk(0, 1, 0, 12, 13, 4, 5, 0, 0, {32'd0, 32'd0}, {32'd11, 32'd22},
                 {32'd5, 32'd4}, {32'd11, 32'd22}, 3);
    vecs[3] = mk(0, 1, 1,  3,  3, 1, 1, 1, 1, {32'd1, 32'd1}, {32'd1, 32'd1},
                 {32'd3, 32'd3}, {32'd3, 32'd3}, 5);
    vecs[4] = mk(0, 0, 1, 21, 20, 9, 9, 32'hFFFF_FFFB, 5, {32'd7, 32'd7}, {32'd10, 32'd20},
                 {32'd7, 32'd7}, {32'd15, 32'd15}, 3);
    vecs[5] = mk(0, 0, 0, 30, 31, 1, 2, 3, 4, {32'd1, 32'd2}, {32'd3, 32'd4},
                 {32'd1, 32'd2}, {32'd3, 32'd4}, 1);
    vecs[6] = mk(1, 1, 0, 40, 41, 32'hAAAA, 32'h5555, 1, 1, {32'd0, 32'd0}, {32'd6, 32'd6},
                 {32'h5555, 32'hAAAA}, {32'd6, 32'd6}, 2);
    vecs[7] = mk(0, 1, 0, 50, 51, 32'hFFFF_FFFF, 1, 0, 0, {32'hFFFF_FFFF, 32'h8000_0000},
                 {32'd0, 32'd0}, {32'd0, 32'h7FFF_FFFF}, {32'd0, 32'd0}, 3);
    vecs[8] = mk(0, 1, 1, 60, 61, 1, 0, 32'hFFFF_FFFF, 0, {32'd0, 32'h7FFF_FFFF},
                 {32'd0, 32'h8000_0000}, {32'd0, 32'h8000_0000}, {32'd0, 32'h7FFF_FFFF}, 5);
    vpost   = mk(1, 1, 1, 90, 91, 11, 12, 13, 14, {32'd0, 32'd0}, {32'd0, 32'd0},
                 {32'd12, 32'd11}, {32'd14, 32'd13}, 3);

    rst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    add_valid = 1'b0; add_overwrite = 1'b0; row_en_1 = 1'b0; row_en_2 = 1'b0;
    row_1_address = '0; row_2_address = '0;
    add_data_00 = '0; add_data_01 = '0; add_data_10 = '0; add_data_11 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 64'(bus0.busy), 64'd0);
    check("reset_ack", 64'(bus0.add_ack), 64'd0);
    check("reset_done", 64'(bus0.add_done), 64'd0);
    check("reset_rd_en", 64'(bus0.mem_rd_en), 64'd0);
    check("reset_wr_en", 64'(bus0.mem_wr_en), 64'd0);
    check("reset_count", 64'(bus0.block_count), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i), last_rd);
      if (i == 3) check("same_row_rd2_data", last_rd, {32'd2, 32'd2});
    end
    check("sat_pos_clamp", mem1[60], {32'd0, 32'h7FFF_FFFF});
    check("sat_neg_clamp", mem1[61], {32'd0, 32'h8000_0000});

    // Valid held through a busy block: ignored until IDLE, then captured with new data.
    @(negedge clk);
    drive(mk(1, 1, 0, 70, 71, 2, 1, 0, 0, '0, '0, '0, '0, 0));
    ack_a = -1; done_a = -1; ack_b = -1; done_b = -1;
    for (int k = 1; k <= 20 && done_b < 0; k++) begin
      @(negedge clk);
      if (bus0.add_ack) begin
        if (ack_a < 0) begin
          ack_a = k;
          drive(mk(1, 1, 0, 71, 70, 4, 3, 0, 0, '0, '0, '0, '0, 0));
        end else begin
          ack_b = k;
          add_valid = 1'b0;
        end
      end
      if (bus0.add_done) begin
        if (done_a < 0) done_a = k;
        else done_b = k;
      end
    end
    @(negedge clk);
    exp_count = exp_count + 16'd2;
    check("b2b_ack_a", 64'(ack_a), 64'd1);
    check("b2b_done_a", 64'(done_a), 64'd2);
    check("b2b_ack_b", 64'(ack_b), 64'd4);
    check("b2b_done_b", 64'(done_b), 64'd5);
    check("b2b_row70", mem0[70], {32'd1, 32'd2});
    check("b2b_row71", mem0[71], {32'd3, 32'd4});
    check("b2b_count", 64'(bus0.block_count), 64'(exp_count));

    // Reset in WR1 of a two-row accumulate: WR1 lands, nothing after it.
    preload(80, {32'd1, 32'd1});
    preload(81, {32'd5, 32'd5});
    wr0 = wr_cnt0; dn0 = done_cnt0;
    @(negedge clk);
    drive(mk(0, 1, 1, 80, 81, 1, 1, 1, 1, '0, '0, '0, '0, 0));
    @(negedge clk);
    check("rst_seq_ack", 64'(bus0.add_ack), 64'd1);
    add_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_in_wr1", 64'(bus0.mem_wr_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_seq_busy", 64'(bus0.busy), 64'd0);
    check("rst_seq_count", 64'(bus0.block_count), 64'd0);
    repeat (6) @(negedge clk);
    check("rst_seq_wr_strobes", 64'(wr_cnt0 - wr0), 64'd1);
    check("rst_seq_no_done", 64'(done_cnt0 - dn0), 64'd0);
    check("rst_seq_row80", mem0[80], {32'd2, 32'd2});
    check("rst_seq_row81", mem0[81], {32'd5, 32'd5});
    exp_count = 16'd0;
    run_vec(vpost, "post_rst", last_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
